pulse_train_gen: RTL and testbench

Programmable pulse-train transmitter: accepts a configuration of high time, low time and pulse count over a valid/ready handshake, then drives a registered pulse waveform on `pulse_out` until the count is exhausted or `abort` is raised. It is the stimulus side of the pulse counters in this codebase. Its output drives counter `start`/`stop`-style inputs or any edge-counting consumer, and `pulses_sent` gives a self-check reference for the receiving counter.

---
 rtl/pulse_train_pkg.sv | 21 ++
 rtl/pulse_train_gen_phase_timer.sv | 34 +++
 rtl/pulse_train_gen.sv | 148 ++++++++++++++
 tb/tb_pulse_train_gen.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/pulse_train_pkg.sv
// ============================================================================
// pulse_train_pkg : shared state encoding and default widths for pulse_train_gen
// Revision        : 1.0
// ============================================================================
`default_nettype none

package pulse_train_pkg;

    localparam int PT_CNT_WIDTH = 8;
    localparam int PT_NUM_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage : pulse_train_pkg

`default_nettype wire

// File: rtl/pulse_train_gen_phase_timer.sv
// ============================================================================
// phase_timer : loadable down-counter; expire marks the last cycle of a phase
// Revision    : 1.0
// ============================================================================
`default_nettype none

module phase_timer #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    output logic                 expire
);

    logic [CNT_WIDTH-1:0] r_count;

    // A phase loaded with value V spans V cycles; the count reads 1 in its last one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_WIDTH'(1);
        end
    end

    assign expire = (r_count == CNT_WIDTH'(1));

endmodule : phase_timer

`default_nettype wire

// File: rtl/pulse_train_gen.sv
// ============================================================================
// pulse_train_gen : programmable pulse-train transmitter with handshake config
// Revision        : 1.0
// ============================================================================
`default_nettype none

module pulse_train_gen
    import pulse_train_pkg::*;
#(
    parameter int CNT_WIDTH = PT_CNT_WIDTH,
    parameter int NUM_WIDTH = PT_NUM_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CNT_WIDTH-1:0] cfg_high,
    input  logic [CNT_WIDTH-1:0] cfg_low,
    input  logic [NUM_WIDTH-1:0] cfg_num,
    input  logic                 abort,
    output logic                 pulse_out,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_WIDTH-1:0] pulses_sent
);

    state_e               r_state;
    state_e               w_state_nxt;

    logic [CNT_WIDTH-1:0] r_high;
    logic [CNT_WIDTH-1:0] r_low;
    logic [NUM_WIDTH-1:0] r_num;
    logic [NUM_WIDTH-1:0] r_sent;

    logic [CNT_WIDTH-1:0] w_cfg_high_sat;
    logic [CNT_WIDTH-1:0] w_cfg_low_sat;
    logic [CNT_WIDTH-1:0] w_load_val;
    logic                 w_load;
    logic                 w_accept;
    logic                 w_inc;
    logic                 w_expire;

    logic                 r_pulse;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_ready;

    // Zero-length phases are stretched to one cycle so the timer always expires.
    assign w_cfg_high_sat = (cfg_high == '0) ? CNT_WIDTH'(1) : cfg_high;
    assign w_cfg_low_sat  = (cfg_low  == '0) ? CNT_WIDTH'(1) : cfg_low;

    phase_timer #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_phase_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .load_val (w_load_val),
        .expire   (w_expire)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        w_load_val  = r_high;
        w_inc       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // abort alongside cfg_valid suppresses the handshake
                if (cfg_valid && !abort) begin
                    w_accept    = 1'b1;
                    w_load      = 1'b1;
                    w_load_val  = w_cfg_high_sat;
                    w_state_nxt = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_expire) begin
                    w_inc       = 1'b1;
                    w_load      = 1'b1;
                    w_load_val  = r_low;
                    w_state_nxt = ST_LOW;
                end
            end
            ST_LOW: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_expire) begin
                    if ((r_num != '0) && (r_sent == r_num)) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_load      = 1'b1;
                        w_load_val  = r_high;
                        w_state_nxt = ST_HIGH;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_high  <= CNT_WIDTH'(1);
            r_low   <= CNT_WIDTH'(1);
            r_num   <= '0;
            r_sent  <= '0;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_high <= w_cfg_high_sat;
                r_low  <= w_cfg_low_sat;
                r_num  <= cfg_num;
                r_sent <= '0;
            end else if (w_inc) begin
                r_sent <= r_sent + NUM_WIDTH'(1);
            end
            // Outputs are flopped decodes of the upcoming state.
            r_pulse <= (w_state_nxt == ST_HIGH);
            r_busy  <= (w_state_nxt == ST_HIGH) || (w_state_nxt == ST_LOW);
            r_done  <= (w_state_nxt == ST_DONE);
            r_ready <= (w_state_nxt == ST_IDLE);
        end
    end

    assign cfg_ready   = r_ready;
    assign pulse_out   = r_pulse;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pulses_sent = r_sent;

endmodule : pulse_train_gen

`default_nettype wire

// File: tb/tb_pulse_train_gen.sv
// ============================================================================
// tb_pulse_train_gen : directed self-checking bench for pulse_train_gen
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_pulse_train_gen;

    logic       clk;
    logic       reset;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_high;
    logic [7:0] cfg_low;
    logic [7:0] cfg_num;
    logic       abort;
    logic       pulse_out;
    logic       busy;
    logic       done;
    logic [7:0] pulses_sent;

    int n_cmp = 0;
    int n_err = 0;

    pulse_train_gen #(
        .CNT_WIDTH (8),
        .NUM_WIDTH (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_high    (cfg_high),
        .cfg_low     (cfg_low),
        .cfg_num     (cfg_num),
        .abort       (abort),
        .pulse_out   (pulse_out),
        .busy        (busy),
        .done        (done),
        .pulses_sent (pulses_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Step to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int h, input int l, input int n);
        cfg_high  = 8'(h);
        cfg_low   = 8'(l);
        cfg_num   = 8'(n);
        cfg_valid = 1'b1;
    endtask

    function automatic logic [31:0] obs_vec();
        return {20'd0, pulse_out, busy, done, cfg_ready, pulses_sent};
    endfunction

    // Expected {pulse,busy,done,ready,sent} in cycle c after accept of a finite train.
    function automatic logic [31:0] exp_vec(input int h, input int l, input int n, input int c);
        int   hh, ll, p, tot, sent;
        logic pu, bu, dn, rd;
        hh   = (h == 0) ? 1 : h;
        ll   = (l == 0) ? 1 : l;
        p    = hh + ll;
        tot  = n * p;
        sent = (c < hh) ? 0 : ((c - hh) / p + 1);
        if (sent > n) sent = n;
        pu = (c < tot) && ((c % p) < hh);
        bu = (c < tot);
        dn = (c == tot);
        rd = (c > tot);
        return {20'd0, pu, bu, dn, rd, 8'(sent)};
    endfunction

    initial begin
        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_high  = 8'd0;
        cfg_low   = 8'd0;
        cfg_num   = 8'd0;
        abort     = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        check_eq("reset_state", obs_vec(), {20'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0});

        // H=3 L=2 N=4, config wiggled mid-train, then back-to-back H=0 L=0 N=2
        offer(3, 2, 4);
        tick();
        cfg_valid = 1'b0;
        for (int c = 0; c < 22; c++) begin
            if (c == 5) begin
                cfg_high = 8'd7;
                cfg_low  = 8'd9;
                cfg_num  = 8'd1;
            end
            if (c == 20) offer(0, 0, 2);
            check_eq($sformatf("t1_cyc%0d", c), obs_vec(), exp_vec(3, 2, 4, c));
            tick();
        end
        cfg_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            check_eq($sformatf("t2_cyc%0d", c), obs_vec(), exp_vec(0, 0, 2, c));
            tick();
        end

        // Continuous H=1 L=1: 260 pulses with a wrap through 255 -> 0
        offer(1, 1, 0);
        tick();
        cfg_valid = 1'b0;
        for (int c = 0; c <= 520; c++) begin
            check_eq($sformatf("cont_cyc%0d", c), obs_vec(),
                     {20'd0, (c % 2 == 0), 1'b1, 1'b0, 1'b0, 8'(((c + 1) / 2) % 256)});
            if (c == 520) abort = 1'b1;
            tick();
        end
        abort = 1'b0;
        check_eq("cont_abort", obs_vec(), {20'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4});

        // H=4 L=4 N=3, abort in 2nd HIGH cycle of pulse 2
        offer(4, 4, 3);
        tick();
        cfg_valid = 1'b0;
        for (int c = 0; c <= 9; c++) begin
            check_eq($sformatf("t4_cyc%0d", c), obs_vec(), exp_vec(4, 4, 3, c));
            if (c == 9) abort = 1'b1;
            tick();
        end
        check_eq("t4_abort", obs_vec(), {20'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1});
        offer(2, 2, 1);
        tick();
        check_eq("t4_abort_blocks_accept", obs_vec(), {20'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1});
        abort     = 1'b0;
        cfg_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_eq($sformatf("t4_idle%0d", c), obs_vec(), {20'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1});
        end

        // Reset during LOW of H=2 L=3 N=2, with cfg_valid at the reset edge
        offer(2, 3, 2);
        tick();
        cfg_valid = 1'b0;
        for (int c = 0; c <= 3; c++) begin
            check_eq($sformatf("t5_cyc%0d", c), obs_vec(), exp_vec(2, 3, 2, c));
            if (c == 3) begin
                reset = 1'b1;
                offer(5, 5, 5);
            end
            tick();
        end
        reset     = 1'b0;
        cfg_valid = 1'b0;
        check_eq("t5_reset", obs_vec(), {20'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0});
        tick();
        check_eq("t5_reset_no_accept", obs_vec(), {20'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_pulse_train_gen

`default_nettype wire
